ram_mp: RTL and testbench

- Flip-flop based multi-port RAM with independent read and write ports and per-byte write strobes.
- Configurable read-during-write behaviour, optional output register, and a hardware init/clear sequencer.
- Shared storage primitive for register files, queues and tables that need several readers and writers.

---
 rtl/ram_mp.sv | 119 +++++++++++
 tb/tb_ram_mp.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_mp.sv
// Flip-flop multi-port RAM with byte strobes, selectable read-during-write,
// optional output register and an INITVAL fill sequencer driven by reset/clr.
module ram_mp #(
  parameter int unsigned DATA    = 32,
  parameter int unsigned BYTE    = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned RPORT   = 2,
  parameter int unsigned WPORT   = 2,
  parameter int unsigned OUTREG  = 0,
  parameter int unsigned RDW     = 0,
  parameter logic [DATA-1:0] INITVAL = '0,
  localparam int unsigned ADDR   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned NB     = DATA / BYTE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  output logic                    busy,
  input  logic [WPORT-1:0]        we_,
  input  logic [WPORT*ADDR-1:0]   waddr,
  input  logic [WPORT*NB-1:0]     wstrb,
  input  logic [WPORT*DATA-1:0]   wdata,
  input  logic [RPORT-1:0]        re_,
  input  logic [RPORT*ADDR-1:0]   raddr,
  output logic [RPORT*DATA-1:0]   rdata,
  output logic [RPORT-1:0]        rvalid
);

  typedef enum logic {S_IDLE, S_INIT} state_t;

  state_t          state;
  logic [ADDR-1:0] cnt;
  logic [DATA-1:0] mem     [DEPTH];
  logic [DATA-1:0] mem_nxt [DEPTH];

  logic [RPORT*DATA-1:0] rd_d;
  logic [RPORT-1:0]      rv_d;

  assign busy = (state == S_INIT);

  // Post-write image of every word. Ports are applied in ascending order so the
  // highest-index port wins a lane conflict; out-of-range addresses match no
  // word and drop naturally. The same image doubles as the RDW=1 forward path.
  always_comb begin
    for (int unsigned w = 0; w < DEPTH; w++) begin
      mem_nxt[w] = mem[w];
      if (state == S_IDLE && !clr) begin
        for (int unsigned p = 0; p < WPORT; p++) begin
          if (!we_[p] && waddr[p*ADDR +: ADDR] == ADDR'(w)) begin
            for (int unsigned b = 0; b < NB; b++) begin
              if (wstrb[p*NB + b])
                mem_nxt[w][b*BYTE +: BYTE] = wdata[p*DATA + b*BYTE +: BYTE];
            end
          end
        end
      end
    end
  end

  // Storage is deliberately left out of the reset branch; the INIT walk clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_INIT;
      cnt   <= '0;
    end else if (state == S_INIT) begin
      for (int unsigned w = 0; w < DEPTH; w++) begin
        if (cnt == ADDR'(w))
          mem[w] <= INITVAL;
      end
      if (clr) begin
        cnt <= '0;
      end else if (cnt == ADDR'(DEPTH - 1)) begin
        cnt   <= '0;
        state <= S_IDLE;
      end else begin
        cnt <= cnt + ADDR'(1);
      end
    end else begin
      for (int unsigned w = 0; w < DEPTH; w++)
        mem[w] <= mem_nxt[w];
      if (clr) begin
        state <= S_INIT;
        cnt   <= '0;
      end
    end
  end

  always_comb begin
    rd_d = '0;
    rv_d = '0;
    for (int unsigned i = 0; i < RPORT; i++) begin
      rv_d[i] = !re_[i] && !busy;
      if (rv_d[i]) begin
        for (int unsigned w = 0; w < DEPTH; w++) begin
          if (raddr[i*ADDR +: ADDR] == ADDR'(w))
            rd_d[i*DATA +: DATA] = (RDW != 0) ? mem_nxt[w] : mem[w];
        end
      end
    end
  end

  if (OUTREG != 0) begin : g_outreg
    always_ff @(posedge clk) begin
      if (reset) begin
        rdata  <= '0;
        rvalid <= '0;
      end else begin
        rdata  <= rd_d;
        rvalid <= rv_d;
      end
    end
  end else begin : g_comb
    always_comb begin
      rdata  = rd_d;
      rvalid = rv_d;
    end
  end

endmodule

// File: tb/tb_ram_mp.sv
// Directed bench for ram_mp: four parameterisations share one stimulus bus and
// are checked against hand-computed values.
module tb_ram_mp;

  logic        clk = 1'b0;
  logic        reset, clr;
  logic [1:0]  we_, re_;
  logic [7:0]  waddr, raddr;
  logic [7:0]  wstrb;
  logic [63:0] wdata;

  logic        busy_a, busy_b, busy_c, busy_d;
  logic [63:0] rdata_a, rdata_b, rdata_c, rdata_d;
  logic [1:0]  rvalid_a, rvalid_b, rvalid_c, rvalid_d;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  // a: comb read, old data; b: registered, old data; c: registered, forwarded; d: 12 words
  ram_mp #(.DATA(32), .BYTE(8), .DEPTH(16), .RPORT(2), .WPORT(2), .OUTREG(0), .RDW(0),
           .INITVAL(32'hA5A5_A5A5)) dut_a (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy_a), .we_(we_), .waddr(waddr),
    .wstrb(wstrb), .wdata(wdata), .re_(re_), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a));

  ram_mp #(.DATA(32), .BYTE(8), .DEPTH(16), .RPORT(2), .WPORT(2), .OUTREG(1), .RDW(0),
           .INITVAL(32'h0)) dut_b (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy_b), .we_(we_), .waddr(waddr),
    .wstrb(wstrb), .wdata(wdata), .re_(re_), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b));

  ram_mp #(.DATA(32), .BYTE(8), .DEPTH(16), .RPORT(2), .WPORT(2), .OUTREG(1), .RDW(1),
           .INITVAL(32'h0)) dut_c (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy_c), .we_(we_), .waddr(waddr),
    .wstrb(wstrb), .wdata(wdata), .re_(re_), .raddr(raddr), .rdata(rdata_c), .rvalid(rvalid_c));

  ram_mp #(.DATA(32), .BYTE(8), .DEPTH(12), .RPORT(2), .WPORT(2), .OUTREG(0), .RDW(0),
           .INITVAL(32'h5A5A_0F0F)) dut_d (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy_d), .we_(we_), .waddr(waddr),
    .wstrb(wstrb), .wdata(wdata), .re_(re_), .raddr(raddr), .rdata(rdata_d), .rvalid(rvalid_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr   = 1'b0;
    we_   = 2'b11;
    re_   = 2'b11;
    waddr = '0;
    raddr = '0;
    wstrb = '0;
    wdata = '0;
  endtask

  task automatic test_reset();
    int unsigned na, nd;
    logic bad;
    idle();
    reset = 1'b1;
    re_   = 2'b00;
    tick();
    tick();
    checks++;
    if (busy_a !== 1'b1 || rvalid_b !== 2'b00 || rdata_b !== 64'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b rvalid=%b rdata=%h, want busy=1 rvalid=00 rdata=0",
               busy_a, rvalid_b, rdata_b);
    end
    reset = 1'b0;
    na = 0; nd = 0; bad = 1'b0;
    while (busy_a && na < 40) begin
      if (rvalid_a !== 2'b00 || rvalid_b !== 2'b00 || rvalid_c !== 2'b00) bad = 1'b1;
      if (busy_b !== 1'b1 || busy_c !== 1'b1) bad = 1'b1;
      if (busy_d) begin
        nd++;
        if (rvalid_d !== 2'b00) bad = 1'b1;
      end
      na++;
      tick();
    end
    checks++;
    if (na != 16) begin
      errors++;
      $display("FAIL init_len16: busy cycles=%0d, want 16", na);
    end
    checks++;
    if (nd != 12) begin
      errors++;
      $display("FAIL init_len12: busy cycles=%0d, want 12", nd);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL init_quiet: rvalid or busy wrong during INIT, want rvalid=0 busy=1");
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      raddr = {4'(15 - k), 4'(k)};
      #1;
      checks++;
      if (rdata_a !== {2{32'hA5A5_A5A5}} || rvalid_a !== 2'b11) begin
        errors++;
        $display("FAIL init_read[%0d]: rdata=%h rvalid=%b, want a5a5a5a5a5a5a5a5 11",
                 k, rdata_a, rvalid_a);
      end
    end
    idle();
  endtask

  task automatic test_out_of_range();
    logic bad;
    tick();
    we_ = 2'b10; waddr = 8'h0D; wdata = {32'h0, 32'hDEAD_DEAD}; wstrb = 8'h0F;
    tick();
    idle();
    re_ = 2'b00; raddr = {4'd12, 4'd13};
    #1;
    checks++;
    if (rvalid_d !== 2'b11 || rdata_d !== 64'h0) begin
      errors++;
      $display("FAIL oor_read: rvalid=%b rdata=%h, want 11 0", rvalid_d, rdata_d);
    end
    checks++;
    if (rdata_a[31:0] !== 32'hDEAD_DEAD) begin
      errors++;
      $display("FAIL inrange_13: rdata=%h, want deaddead", rdata_a[31:0]);
    end
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      raddr = {4'(11 - k), 4'(k)};
      #1;
      if (rdata_d !== {2{32'h5A5A_0F0F}}) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL oor_untouched: some word of 0..11 changed, want 5a5a0f0f everywhere");
    end
    idle();
  endtask

  task automatic test_byte_strobe();
    tick();
    we_ = 2'b10; waddr = 8'h03; wdata = {32'h0, 32'h1122_3344}; wstrb = 8'h0F;
    tick();
    wdata = {32'h0, 32'hFFFF_FFFF}; wstrb = 8'h05;
    tick();
    idle();
    re_ = 2'b10; raddr = 8'h03;
    #1;
    checks++;
    if (rdata_a[31:0] !== 32'h11FF_33FF) begin
      errors++;
      $display("FAIL byte_strobe: rdata=%h, want 11ff33ff", rdata_a[31:0]);
    end
    idle();
  endtask

  task automatic test_conflict();
    tick();
    we_ = 2'b00; waddr = 8'h55; wdata = {32'h0000_1234, 32'hDEAD_BEEF}; wstrb = 8'hFF;
    tick();
    idle();
    re_ = 2'b10; raddr = 8'h05;
    #1;
    checks++;
    if (rdata_a[31:0] !== 32'h0000_1234) begin
      errors++;
      $display("FAIL conflict_full: rdata=%h, want 00001234", rdata_a[31:0]);
    end
    tick();
    we_ = 2'b00; waddr = 8'h55; wdata = {32'h0000_1234, 32'hDEAD_BEEF}; wstrb = 8'h3F;
    tick();
    idle();
    re_ = 2'b10; raddr = 8'h05;
    #1;
    checks++;
    if (rdata_a[31:0] !== 32'hDEAD_1234) begin
      errors++;
      $display("FAIL conflict_merge: rdata=%h, want dead1234", rdata_a[31:0]);
    end
    tick();
    we_ = 2'b10; waddr = 8'h05; wdata = '0; wstrb = 8'h00;
    tick();
    idle();
    re_ = 2'b10; raddr = 8'h05;
    #1;
    checks++;
    if (rdata_a[31:0] !== 32'hDEAD_1234) begin
      errors++;
      $display("FAIL zero_strobe: rdata=%h, want dead1234", rdata_a[31:0]);
    end
    idle();
  endtask

  task automatic test_rdw();
    tick();
    we_ = 2'b10; waddr = 8'h07; wdata = {32'h0, 32'h0000_00AA}; wstrb = 8'h0F;
    re_ = 2'b10; raddr = 8'h07;
    #1;
    checks++;
    if (rdata_a[31:0] !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL rdw_comb_old: rdata=%h, want a5a5a5a5", rdata_a[31:0]);
    end
    tick();
    checks++;
    if (rdata_b !== 64'h0 || rvalid_b !== 2'b01) begin
      errors++;
      $display("FAIL rdw0_reg: rdata=%h rvalid=%b, want 0 01", rdata_b, rvalid_b);
    end
    checks++;
    if (rdata_c !== 64'h0000_00AA || rvalid_c !== 2'b01) begin
      errors++;
      $display("FAIL rdw1_reg: rdata=%h rvalid=%b, want 00000000000000aa 01", rdata_c, rvalid_c);
    end
    idle();
    tick();
    checks++;
    if (rvalid_b !== 2'b00 || rdata_b !== 64'h0 || rvalid_c !== 2'b00 || rdata_c !== 64'h0) begin
      errors++;
      $display("FAIL rdw_idle: rvalid=%b/%b rdata=%h/%h, want 00/00 0/0",
               rvalid_b, rvalid_c, rdata_b, rdata_c);
    end
    re_ = 2'b10; raddr = 8'h07;
    tick();
    checks++;
    if (rdata_b[31:0] !== 32'h0000_00AA) begin
      errors++;
      $display("FAIL rdw0_after: rdata=%h, want 000000aa", rdata_b[31:0]);
    end
    idle();
  endtask

  task automatic test_clr();
    int unsigned n;
    logic bad;
    tick();
    clr = 1'b1;
    we_ = 2'b10; waddr = 8'h02; wdata = {32'h0, 32'h1234_5678}; wstrb = 8'h0F;
    tick();
    idle();
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL clr_busy: busy=%b, want 1", busy_a);
    end
    // hammer word 0 (already re-initialised) while INIT continues
    we_ = 2'b10; waddr = 8'h00; wdata = {32'h0, 32'hFFFF_FFFF}; wstrb = 8'h0F;
    re_ = 2'b00;
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (busy_a !== 1'b1 || rvalid_a !== 2'b00) bad = 1'b1;
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n = 0;
    while (busy_a && n < 40) begin
      if (rvalid_a !== 2'b00 || rdata_a !== 64'h0) bad = 1'b1;
      n++;
      tick();
    end
    idle();
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL clr_restart: busy cycles=%0d, want 16", n);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL clr_quiet: busy/rvalid/rdata wrong during INIT, want busy=1 rvalid=0 rdata=0");
    end
    bad = 1'b0;
    re_ = 2'b00;
    for (int k = 0; k < 16; k++) begin
      tick();
      raddr = {4'(15 - k), 4'(k)};
      #1;
      if (rdata_a !== {2{32'hA5A5_A5A5}}) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL clr_fill: some word not a5a5a5a5 after re-init");
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_out_of_range();
    test_byte_strobe();
    test_conflict();
    test_rdw();
    test_clr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
